// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: 32-bit operands, {remainder, quotient} result.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor finishes in one cycle through BY_ZERO.
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
`ifdef DIV_ZERO_FASTPATH_EN
        BY_ZERO = 2'd1,
`endif
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [5:0]  cnt;
    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [31:0] quot_q;
    logic [31:0] rem_q;
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic        zero_div_q;

    logic        accept;
    logic [32:0] rem_shift;
    logic        no_borrow;
    logic [31:0] rem_sub;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign accept = start_i && !annul_i;

    // When no borrow occurs the true difference is below the divisor, so the low 32 bits are exact.
    assign rem_shift = {rem_q, dividend_q[31]};
    assign no_borrow = rem_shift >= {1'b0, divisor_q};
    assign rem_sub   = rem_shift[31:0] - divisor_q;
    assign quot_fix  = neg_quot_q ? 32'd0 - quot_q : quot_q;
    assign rem_fix   = neg_rem_q  ? 32'd0 - rem_q  : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        busy_o  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    state_d = (opdata2_i == 32'd0) ? BY_ZERO : ON;
`else
                    state_d = ON;
`endif
                end
            end
`ifdef DIV_ZERO_FASTPATH_EN
            BY_ZERO: begin
                busy_o  = 1'b1;
                state_d = annul_i ? IDLE : END;
            end
`endif
            ON: begin
                busy_o = 1'b1;
                if (annul_i) begin
                    state_d = IDLE;
                end else if (cnt == 6'd32) begin
                    state_d = END;
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operands and partial remainder are cleared too, so no stale data survives a reset.
            cnt        <= 6'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dividend_q <= (signed_div_i && opdata1_i[31]) ? 32'd0 - opdata1_i : opdata1_i;
                        divisor_q  <= (signed_div_i && opdata2_i[31]) ? 32'd0 - opdata2_i : opdata2_i;
                        neg_quot_q <= signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem_q  <= signed_div_i && opdata1_i[31];
                        zero_div_q <= (opdata2_i == 32'd0);
                        quot_q     <= 32'd0;
                        rem_q      <= 32'd0;
                        cnt        <= 6'd0;
                    end
                end
`ifdef DIV_ZERO_FASTPATH_EN
                BY_ZERO: begin
                    if (!annul_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b1;
                    end
                end
`endif
                ON: begin
                    if (!annul_i) begin
                        if (cnt != 6'd32) begin
                            dividend_q <= {dividend_q[30:0], 1'b0};
                            rem_q      <= no_borrow ? rem_sub : rem_shift[31:0];
                            quot_q     <= {quot_q[30:0], no_borrow};
                            cnt        <= cnt + 6'd1;
                        end else begin
                            result_o <= zero_div_q ? 64'd0 : {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= 64'd0;
                        ready_o  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed divisions, annul, reset and END-hold scenarios,
// with a cycle-level reference model compared against the DUT outputs every cycle.
module tb_div_ctrl;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: truncating division on sign- or zero-extended 64-bit values.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Transaction-level model: a countdown to the result edge, then a held result until released.
    int          busy_left = 0;
    bit          m_ready   = 1'b0;
    logic [63:0] m_res     = 64'd0;
    logic [63:0] pend_res  = 64'd0;

    always @(posedge clk) begin
        if (rst) begin
            busy_left = 0;
            m_ready   = 1'b0;
            m_res     = 64'd0;
        end else if (busy_left > 0) begin
            if (annul_i) begin
                busy_left = 0;
            end else begin
                busy_left--;
                if (busy_left == 0) begin
                    m_ready = 1'b1;
                    m_res   = pend_res;
                end
            end
        end else if (m_ready) begin
            if (annul_i || !start_i) begin
                m_ready = 1'b0;
                m_res   = 64'd0;
            end
        end else if (start_i && !annul_i) begin
            pend_res  = ref_div(signed_div_i, opdata1_i, opdata2_i);
            busy_left = (opdata2_i == 32'd0) ? ZERO_LAT : 33;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy",   64'(busy_o),  64'(busy_left > 0));
            check("cyc_ready",  64'(ready_o), 64'(m_ready));
            check("cyc_result", result_o,     m_res);
            check("cyc_excl",   64'(ready_o & busy_o), 64'd0);
        end
    end

    // Called one step after the accept edge; annul_end releases END by annul instead of start.
    task automatic wait_result(input string name, input logic [63:0] exp, input int lat,
                               input int hold, input bit annul_end);
        int n  = 0;
        int bc = 0;
        while (!ready_o && n < 100) begin
            if (busy_o) bc++;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_lat"},  64'(n),  64'(lat));
        check({name, "_busy"}, 64'(bc), 64'(lat));
        check({name, "_res"},  result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, "_hold_rdy"}, 64'(ready_o), 64'd1);
            check({name, "_hold_res"}, result_o, exp);
        end
        if (annul_end) begin
            annul_i = 1'b1;
            @(posedge clk); #1;
            annul_i = 1'b0;
            start_i = 1'b0;
        end else begin
            start_i = 1'b0;
            @(posedge clk); #1;
        end
        check({name, "_rel_rdy"}, 64'(ready_o), 64'd0);
        check({name, "_rel_res"}, result_o, 64'd0);
        if (annul_end) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat, input int hold, input bit annul_end);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        wait_result(name, exp, lat, hold, annul_end);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        check("rst_ready",  64'(ready_o), 64'd0);
        check("rst_busy",   64'(busy_o),  64'd0);
        check("rst_result", result_o,     64'd0);

        run_div("divu_100_7",   1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0, 1'b0);
        run_div("div_m7_2",     1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD},    33, 0, 1'b0);
        run_div("div_7_m2",     1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD},    33, 0, 1'b0);
        run_div("divu_max_1",   1'b0, 32'hFFFFFFFF,   32'd1,          {32'd0, 32'hFFFFFFFF},           33, 0, 1'b0);
        run_div("divu_5_0",     1'b0, 32'd5,          32'd0,          64'd0,                           ZERO_LAT, 0, 1'b0);
        run_div("div_m100_m7",  1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E},    33, 0, 1'b0);
        run_div("divu_fff9_2",  1'b0, 32'hFFFFFFF9,   32'd2,          {32'h00000001, 32'h7FFFFFFC},    33, 0, 1'b0);
        run_div("div_min_m1",   1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'd0, 32'h80000000},           33, 0, 1'b0);
        run_div("div_end_hold", 1'b0, 32'd77,         32'd10,         {32'd7, 32'd7},                  33, 4, 1'b0);
        run_div("div_end_annul",1'b0, 32'd12345,      32'd100,        {32'd45, 32'd123},               33, 0, 1'b1);

        // Annul in ON, then a new request held straight through is accepted.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        check("annul_on_busy",  64'(busy_o),  64'd0);
        check("annul_on_ready", 64'(ready_o), 64'd0);
        annul_i   = 1'b0;
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        @(posedge clk); #1;
        wait_result("after_annul", {32'd0, 32'd10}, 33, 0, 1'b0);

        // Annul in IDLE blocks acceptance.
        opdata1_i = 32'd20;
        opdata2_i = 32'd4;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("annul_idle_busy", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        @(posedge clk); #1;

        // Reset mid-division, then a normal division.
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        start_i = 1'b0;
        check("mid_rst_busy",   64'(busy_o),  64'd0);
        check("mid_rst_ready",  64'(ready_o), 64'd0);
        check("mid_rst_result", result_o,     64'd0);
        @(posedge clk); #1;
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
